// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result bus between a control unit (master)
// and the multi-cycle serial subtractor (slave). Carries the start/busy/done
// handshake, the operands and the registered result with its flags.
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [WIDTH-1:0] In_A;
  logic [WIDTH-1:0] In_B;
  logic             Borrow_in;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Difference;
  logic             Borrow_out;
  logic             Overflow;
  logic             Zero;

  modport master (
    output Start, In_A, In_B, Borrow_in,
    input  Busy, Done, Difference, Borrow_out, Overflow, Zero
  );

  modport slave (
    input  Start, In_A, In_B, Borrow_in,
    output Busy, Done, Difference, Borrow_out, Overflow, Zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes In_A - In_B - Borrow_in over WIDTH/DIGIT clock
// cycles using a DIGIT-bit ripple-borrow chain of full-subtractor slices.
// Results and flags are registered and only change when an operation ends.
// Optional feature macro: SERIAL_SUBTRACTOR_FLAGS_EN (Overflow/Zero flags).
// When it is undefined, Overflow and Zero are tied to 0.
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input logic Clk,
  input logic Rst,
  serial_subtractor_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_subtractor: WIDTH must be >= 2 and divisible by DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [WIDTH-1:0] d_next;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             bout_q;
  logic [DIGIT-1:0] dig;
  logic             chain_bout;

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  logic msb_bin;
  logic ovf_q;
  logic zero_q;

  // Signed overflow: borrow into the MSB slice differs from the borrow out.
  function automatic logic ovf_flag(input logic bin_msb, input logic bout_msb);
    return bin_msb ^ bout_msb;
  endfunction

  function automatic logic zero_flag(input logic [WIDTH-1:0] d);
    return ~|d;
  endfunction
`endif

  // Ripple-borrow chain over the low DIGIT bits of the operand shift registers
  always_comb begin
    dig        = '0;
    chain_bout = borrow_q;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    msb_bin    = borrow_q;
`endif
    for (int i = 0; i < DIGIT; i++) begin
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
      // Left holding the borrow into the top slice, i.e. bit WIDTH-1 on the last pass
      msb_bin    = chain_bout;
`endif
      dig[i]     = a_sr[i] ^ b_sr[i] ^ chain_bout;
      chain_bout = (~a_sr[i] & b_sr[i]) | (~(a_sr[i] ^ b_sr[i]) & chain_bout);
    end
    // New difference digit enters at the MSB end; after N cycles it is aligned
    d_next = (d_sr >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
  end

  // Next-state logic: Start only matters in IDLE, DONE always returns to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.Start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand/result shift registers, iteration counter and result registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      d_sr     <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            a_sr     <= bus.In_A;
            b_sr     <= bus.In_B;
            borrow_q <= bus.Borrow_in;
            d_sr     <= '0;
            cnt      <= '0;
          end
        end
        RUN: begin
          a_sr     <= a_sr >> DIGIT;
          b_sr     <= b_sr >> DIGIT;
          d_sr     <= d_next;
          borrow_q <= chain_bout;
          cnt      <= cnt + CW'(1);
          // Final digit: publish the full result so it is valid during DONE
          if (cnt == LAST) begin
            diff_q <= d_next;
            bout_q <= chain_bout;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
            ovf_q  <= ovf_flag(msb_bin, chain_bout);
            zero_q <= zero_flag(d_next);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy       = (state == RUN);
  assign bus.Done       = (state == DONE);
  assign bus.Difference = diff_q;
  assign bus.Borrow_out = bout_q;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  assign bus.Overflow   = ovf_q;
  assign bus.Zero       = zero_q;
`else
  assign bus.Overflow   = 1'b0;
  assign bus.Zero       = 1'b0;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed tests of an 8-bit/1-bit-digit instance and
// a 32-bit/8-bit-digit instance of serial_subtractor.
module tb_serial_subtractor;
  logic Clk = 1'b0;
  logic rst8;
  logic rst32;
  int   checks = 0;
  int   errors = 0;

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  always #5 Clk = ~Clk;

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(32)) bus32 ();

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
    .Clk (Clk),
    .Rst (rst8),
    .bus (bus8.slave)
  );

  serial_subtractor #(.WIDTH(32), .DIGIT(8)) dut32 (
    .Clk (Clk),
    .Rst (rst32),
    .bus (bus32.slave)
  );

  // Start one 8-bit operation and wait (bounded) for Done; lat counts samples
  // after the Start edge up to and including the Done sample.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      output int lat, output int busy_n);
    @(negedge Clk);
    bus8.Start = 1'b1; bus8.In_A = a; bus8.In_B = b; bus8.Borrow_in = bin;
    lat = 0; busy_n = 0;
    @(negedge Clk);
    bus8.Start = 1'b0; bus8.In_A = 8'h00; bus8.In_B = 8'h00; bus8.Borrow_in = 1'b0;
    while (1) begin
      lat++;
      if (bus8.Busy) busy_n++;
      if (bus8.Done || lat >= 40) break;
      @(negedge Clk);
    end
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic bin,
                       output int lat);
    @(negedge Clk);
    bus32.Start = 1'b1; bus32.In_A = a; bus32.In_B = b; bus32.Borrow_in = bin;
    lat = 0;
    @(negedge Clk);
    bus32.Start = 1'b0;
    while (1) begin
      lat++;
      if (bus32.Done || lat >= 40) break;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    rst8 = 1'b1; rst32 = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({bus8.Busy, bus8.Done, bus8.Difference, bus8.Borrow_out, bus8.Overflow, bus8.Zero} !== 12'h000) begin
      errors++;
      $display("FAIL reset8 got busy=%b done=%b diff=%h bout=%b ovf=%b zero=%b expected all 0",
               bus8.Busy, bus8.Done, bus8.Difference, bus8.Borrow_out, bus8.Overflow, bus8.Zero);
    end
    checks++;
    if ({bus32.Busy, bus32.Done, bus32.Difference, bus32.Borrow_out, bus32.Overflow, bus32.Zero} !== 36'h0) begin
      errors++;
      $display("FAIL reset32 got busy=%b done=%b diff=%h expected all 0",
               bus32.Busy, bus32.Done, bus32.Difference);
    end
    rst8 = 1'b0; rst32 = 1'b0;
  endtask

  task automatic test_basic();
    int lat, busy_n;
    run8(8'h05, 8'h03, 1'b0, lat, busy_n);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL basic_latency got %0d expected 9", lat); end
    checks++;
    if (busy_n !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d expected 8", busy_n); end
    checks++;
    if ({bus8.Difference, bus8.Borrow_out, bus8.Overflow, bus8.Zero} !== {8'h02, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_result got diff=%h bout=%b ovf=%b zero=%b expected 02 0 0 0",
               bus8.Difference, bus8.Borrow_out, bus8.Overflow, bus8.Zero);
    end
    @(negedge Clk);
    checks++;
    if ({bus8.Done, bus8.Busy, bus8.Difference} !== {1'b0, 1'b0, 8'h02}) begin
      errors++;
      $display("FAIL basic_pulse_hold got done=%b busy=%b diff=%h expected 0 0 02",
               bus8.Done, bus8.Busy, bus8.Difference);
    end
  endtask

  task automatic test_wrap_overflow();
    logic [7:0] va [3] = '{8'h00, 8'h80, 8'h7F};
    logic [7:0] vb [3] = '{8'h01, 8'h01, 8'hFF};
    logic [7:0] ed [3] = '{8'hFF, 8'h7F, 8'h80};
    logic       eb [3] = '{1'b1, 1'b0, 1'b1};
    logic       eo [3] = '{1'b0, 1'b1, 1'b1};
    int lat, busy_n;
    for (int i = 0; i < 3; i++) begin
      run8(va[i], vb[i], 1'b0, lat, busy_n);
      checks++;
      if ({bus8.Done, bus8.Difference, bus8.Borrow_out, bus8.Overflow, bus8.Zero} !==
          {1'b1, ed[i], eb[i], eo[i] & FLAGS, 1'b0}) begin
        errors++;
        $display("FAIL wrap_ovf[%0d] got done=%b diff=%h bout=%b ovf=%b zero=%b expected 1 %h %b %b 0",
                 i, bus8.Done, bus8.Difference, bus8.Borrow_out, bus8.Overflow, bus8.Zero,
                 ed[i], eb[i], eo[i] & FLAGS);
      end
    end
  endtask

  task automatic test_borrow_zero();
    int lat, busy_n;
    run8(8'h03, 8'h02, 1'b1, lat, busy_n);
    checks++;
    if ({bus8.Difference, bus8.Borrow_out, bus8.Overflow, bus8.Zero} !== {8'h00, 1'b0, 1'b0, FLAGS}) begin
      errors++;
      $display("FAIL borrow_zero_a got diff=%h bout=%b ovf=%b zero=%b expected 00 0 0 %b",
               bus8.Difference, bus8.Borrow_out, bus8.Overflow, bus8.Zero, FLAGS);
    end
    run8(8'h00, 8'hFF, 1'b1, lat, busy_n);
    checks++;
    if ({bus8.Difference, bus8.Borrow_out, bus8.Overflow, bus8.Zero} !== {8'h00, 1'b1, 1'b0, FLAGS}) begin
      errors++;
      $display("FAIL borrow_zero_b got diff=%h bout=%b ovf=%b zero=%b expected 00 1 0 %b",
               bus8.Difference, bus8.Borrow_out, bus8.Overflow, bus8.Zero, FLAGS);
    end
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    logic [7:0] got = 8'h00;
    @(negedge Clk);
    bus8.Start = 1'b1; bus8.In_A = 8'h10; bus8.In_B = 8'h01; bus8.Borrow_in = 1'b0;
    for (int s = 1; s <= 30; s++) begin
      @(negedge Clk);
      bus8.Start = (s == 3);
      bus8.In_A  = (s == 3) ? 8'hAA : 8'h00;
      bus8.In_B  = 8'h00;
      if (bus8.Done) begin dones++; got = bus8.Difference; end
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL busy_start_dones got %0d expected 1", dones); end
    checks++;
    if (got !== 8'h0F) begin errors++; $display("FAIL busy_start_diff got %h expected 0f", got); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int lat, busy_n;
    @(negedge Clk);
    bus8.Start = 1'b1; bus8.In_A = 8'h33; bus8.In_B = 8'h11; bus8.Borrow_in = 1'b0;
    @(negedge Clk);
    bus8.Start = 1'b0;
    repeat (3) @(negedge Clk);
    rst8 = 1'b1;
    @(negedge Clk);
    rst8 = 1'b0;
    checks++;
    if ({bus8.Busy, bus8.Done, bus8.Difference, bus8.Borrow_out, bus8.Overflow, bus8.Zero} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_outputs got busy=%b done=%b diff=%h bout=%b expected all 0",
               bus8.Busy, bus8.Done, bus8.Difference, bus8.Borrow_out);
    end
    for (int s = 0; s < 15; s++) begin
      @(negedge Clk);
      if (bus8.Done || bus8.Busy) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL reset_mid_activity got %0d expected 0", dones); end
    run8(8'h09, 8'h04, 1'b0, lat, busy_n);
    checks++;
    if ({lat[7:0], bus8.Difference} !== {8'd9, 8'h05}) begin
      errors++;
      $display("FAIL reset_mid_rerun got lat=%0d diff=%h expected 9 05", lat, bus8.Difference);
    end
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    logic [7:0] held = 8'h00;
    logic [7:0] second = 8'h00;
    @(negedge Clk);
    bus8.Start = 1'b1; bus8.In_A = 8'h20; bus8.In_B = 8'h10; bus8.Borrow_in = 1'b0;
    for (int s = 1; s <= 40; s++) begin
      @(negedge Clk);
      if (s == 1) bus8.In_A = 8'h30;
      if (bus8.Done) begin
        if (d1 < 0) d1 = s;
        else if (d2 < 0) d2 = s;
      end
      if (d1 > 0 && s == d1 + 3) held = bus8.Difference;
      if (d2 > 0) begin second = bus8.Difference; break; end
    end
    bus8.Start = 1'b0;
    checks++;
    if (d1 !== 9) begin errors++; $display("FAIL b2b_first_done got %0d expected 9", d1); end
    checks++;
    if (d2 - d1 !== 10) begin errors++; $display("FAIL b2b_spacing got %0d expected 10", d2 - d1); end
    checks++;
    if (held !== 8'h10) begin errors++; $display("FAIL b2b_hold got %h expected 10", held); end
    checks++;
    if (second !== 8'h20) begin errors++; $display("FAIL b2b_second got %h expected 20", second); end
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_wide();
    int lat;
    logic [31:0] a, b, ed;
    logic        bin, eb, eo, ez;
    logic [32:0] full;
    longint      sv;
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0:       begin a = 32'h1234_5678; b = 32'h1234_5678; bin = 1'b0; end
        1:       begin a = 32'h8000_0000; b = 32'h0000_0000; bin = 1'b1; end
        2:       begin a = 32'h7FFF_FFFF; b = 32'hFFFF_FFFF; bin = 1'b0; end
        default: begin a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1)); end
      endcase
      full = {1'b0, a} - {1'b0, b} - {32'd0, bin};
      ed = full[31:0];
      eb = full[32];
      sv = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
      eo = FLAGS & ((sv > 64'sd2147483647) || (sv < -64'sd2147483648));
      ez = FLAGS & (ed == 32'h0);
      run32(a, b, bin, lat);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL wide_latency[%0d] got %0d expected 5", i, lat); end
      checks++;
      if ({bus32.Difference, bus32.Borrow_out, bus32.Overflow, bus32.Zero} !== {ed, eb, eo, ez}) begin
        errors++;
        $display("FAIL wide_result[%0d] a=%h b=%h bin=%b got %h %b %b %b expected %h %b %b %b",
                 i, a, b, bin, bus32.Difference, bus32.Borrow_out, bus32.Overflow, bus32.Zero,
                 ed, eb, eo, ez);
      end
    end
  endtask

  initial begin
    bus8.Start = 1'b0;  bus8.In_A = '0;  bus8.In_B = '0;  bus8.Borrow_in = 1'b0;
    bus32.Start = 1'b0; bus32.In_A = '0; bus32.In_B = '0; bus32.Borrow_in = 1'b0;
    test_reset();
    test_basic();
    test_wrap_overflow();
    test_borrow_zero();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle, parametrised N-bit subtractor that computes `In_A - In_B - Borrow_in` by iterating a ripple-borrow full-subtractor slice over `DIGIT` bits per clock. It is the sequential, width-generic successor to the single-bit full subtractor in the Lab ALU datapath. It trades latency for area and exposes a start/busy/done handshake to the surrounding control unit.

## Interface
- `WIDTH`, default 32: operand and result width in bits; ≥ 2.
- `DIGIT`, default 1: bits processed per cycle; must divide `WIDTH` exactly. Non-divisor values are an elaboration error.
- `Clk` input, 1 bit: the block's only clock; all state changes on its rising edge.
- `Rst` input, 1 bit: synchronous, active-high reset.
- `Start` input, 1 bit: request a subtraction; sampled only in IDLE.
- `In_A` input, `WIDTH` bits: minuend; sampled with `Start`.
- `In_B` input, `WIDTH` bits: subtrahend; sampled with `Start`.
- `Borrow_in` input, 1 bit: incoming borrow; sampled with `Start`.
- `Busy` output, 1 bit: high while in RUN.
- `Done` output, 1 bit: one-cycle pulse when the result becomes valid.
- `Difference` output, `WIDTH` bits: `(In_A - In_B - Borrow_in) mod 2^WIDTH`.
- `Borrow_out` output, 1 bit: unsigned borrow out of the MSB.
- `Overflow` output, 1 bit: signed overflow flag (see Configuration).
- `Zero` output, 1 bit: high when `Difference == 0` (see Configuration).

## Operation
- States are IDLE, RUN and DONE. `N = WIDTH/DIGIT` is the iteration count, held in a counter of width `$clog2(N+1)`.
- **IDLE:**
  - `Start = 1` latches `In_A`, `In_B` and `Borrow_in` into internal shift registers and a borrow flop.
  - Clears the counter and moves to RUN.
  - `Start = 0` stays in IDLE.
- **RUN, each cycle:**
  - A `DIGIT`-bit ripple chain of full-subtractor slices consumes the low `DIGIT` bits of A and B plus the borrow flop.
  - The `DIGIT` difference bits shift into the MSB end of the result shift register.
  - A and B shift right by `DIGIT`.
  - The borrow flop takes the chain's borrow out, and the counter increments.
  - When the counter reaches `N-1`, the state moves to DONE.
- **DONE:**
  - Output registers load: `Difference` from the shift register, `Borrow_out` from the borrow flop, and the flags.
  - `Done = 1` for exactly this cycle.
  - Next state is IDLE unconditionally.
- **Start handling:**
  - `Start` in RUN or DONE is ignored, not queued; operands change nothing.
  - `Start` held high continuously gives back-to-back operations separated by one IDLE cycle.
- **Output holding:** outputs hold their last completed result through IDLE and RUN until the next DONE. Partial results are never visible.
- **Arithmetic:**
  - Unsigned: `Borrow_out = 1` iff `In_A < In_B + Borrow_in`.
  - `Overflow = 1` iff the two's-complement value `A - B - Bin` lies outside `[-2^(WIDTH-1), 2^(WIDTH-1)-1]`. Equivalently, the borrow into the MSB XOR the borrow out of the MSB.
- **Reset:**
  - `Rst = 1` forces IDLE, clears the counter and shift registers, and sets `Busy`, `Done`, `Difference`, `Borrow_out`, `Overflow` and `Zero` all to 0.
  - Reset mid-RUN aborts the operation; no `Done` pulse is produced.
  - Reset has priority over `Start`.

## Timing
- `Start` sampled at edge k (IDLE) gives `Busy = 1` after edges k through k+N-1.
- State is DONE after edge k+N: `Done = 1`, `Busy = 0`, results valid.
- Latency is `N+1` cycles from the `Start` edge to results valid. Throughput is one result per `N+2` cycles.
- `DIGIT = WIDTH` gives N = 1: RUN lasts one cycle and `Done` appears 2 cycles after `Start`.
- Critical path is one `DIGIT`-bit ripple-borrow chain. No combinational path exists from any input to any output.

## Configuration
- Macro: `SERIAL_SUBTRACTOR_FLAGS_EN`.
- Defined: `Overflow` and `Zero` are computed and registered at DONE as specified above.
- Undefined:
  - Flag logic and its registers are not compiled in.
  - `Overflow` and `Zero` are constant 0, and the ports remain present.
  - `Difference`, `Borrow_out` and the handshake are unchanged.

## Test plan
- **Basic subtraction and latency** (WIDTH=8, DIGIT=1, flags enabled): A=0x05, B=0x03, Bin=0 → `Done` 9 cycles after the `Start` edge, Diff=0x02, Bout=0, Ovf=0, Zero=0; `Busy` high exactly 8 cycles.
- **Unsigned wrap and signed overflow:**
  - A=0x00, B=0x01 → Diff=0xFF, Bout=1, Ovf=0.
  - A=0x80, B=0x01 → Diff=0x7F, Bout=0, Ovf=1.
  - A=0x7F, B=0xFF → Diff=0x80, Bout=1, Ovf=1.
- **Borrow_in and Zero flag:** A=0x03, B=0x02, Bin=1 → Diff=0x00, Zero=1, Bout=0. A=0x00, B=0xFF, Bin=1 → Diff=0x00, Bout=1, Zero=1.
- **Start while busy:** issue A=0x10, B=0x01, then pulse `Start` with A=0xAA during RUN → single `Done`, Diff=0x0F, no second operation begins.
- **Reset mid-operation:** assert `Rst` at RUN cycle 4 → next cycle all outputs 0, state IDLE, no `Done`. A new Start with A=0x09, B=0x04 then completes with Diff=0x05.
- **Wide digit, random sweep, flags macro off:** WIDTH=32, DIGIT=8 → `Done` 5 cycles after Start. 1000 random A/B/Bin checked against a reference model; `Overflow`/`Zero` stay 0 with the macro undefined.
